// File: rtl/uart_rx_chk_if.sv
// uart_rx_chk_if: serial-line and receive-result bundle for uart_rx_chk.
//
// Handshake: the result side is a valid-only strobe with no ready. donerx
// is high for exactly one clk cycle per completed frame. datarx, par_bit_rx,
// par_err and frame_err are loaded on that same edge and then held until the
// next completed frame, so a consumer may sample them with donerx or later.
// rx is an asynchronous, idle-high serial input with no handshake.
//
// state_dbg mirrors the receiver FSM state encoding for observation only.
interface uart_rx_chk_if;
  logic       rx;
  logic [7:0] datarx;
  logic       donerx;
  logic       par_bit_rx;
  logic       par_err;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  // Line side: drives the serial pin and consumes received bytes.
  modport master (
    output rx,
    input  datarx,
    input  donerx,
    input  par_bit_rx,
    input  par_err,
    input  frame_err,
    input  busy,
    input  state_dbg
  );

  // Receiver side.
  modport slave (
    input  rx,
    output datarx,
    output donerx,
    output par_bit_rx,
    output par_err,
    output frame_err,
    output busy,
    output state_dbg
  );
endinterface

// File: rtl/uart_rx_chk.sv
// uart_rx_chk: checked UART receiver.
//
// Receives start, 8 data bits LSB first, an optional even-parity bit and one
// stop bit. The rx line is double-flopped, a start is detected on a 1->0 edge
// of the synchronised line, re-checked at mid start bit, and every later bit
// is sampled at its centre.
//
// Build option: define UART_RX_PARITY_EN for an 11-bit frame with the
// parity bit checked (PARITY state present, par_err/par_bit_rx live).
// Without it the frame is 8N1 and par_err/par_bit_rx are tied to 0.
module uart_rx_chk #(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_chk_if.slave  bus
);

  localparam int unsigned BIT_CYC  = clk_freq / baud_rate;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CW       = (BIT_CYC < 2) ? 1 : $clog2(BIT_CYC);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

  // Below four clocks per bit the mid-bit start check has no room to work.
  generate
    if (BIT_CYC < 4) begin : g_bad_cfg
      $error("uart_rx_chk: clk_freq/baud_rate must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Synchroniser and edge-detect history; all idle-high so reset never
  // looks like a start edge.
  logic sync1_q, sync2_q, prev_q;
  logic line;
  logic fall;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_tick;

  logic          done_q, done_d;
  logic [7:0]    datarx_q, datarx_d;
  logic          frame_err_q, frame_err_d;

`ifdef UART_RX_PARITY_EN
  // par_smp/par_chk hold the parity result between the PARITY and STOP
  // samples so the visible flags only move on the donerx edge.
  logic par_smp_q, par_smp_d;
  logic par_chk_q, par_chk_d;
  logic par_bit_q, par_bit_d;
  logic par_err_q, par_err_d;
`endif

  // Two-flop synchroniser plus one history flop for the falling-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign line     = sync2_q;
  assign fall     = prev_q & ~sync2_q;
  assign bit_tick = (cnt_q == BIT_LAST);

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      datarx_q    <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_smp_q   <= 1'b0;
      par_chk_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      datarx_q    <= datarx_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_smp_q   <= par_smp_d;
      par_chk_q   <= par_chk_d;
      par_bit_q   <= par_bit_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Next-state, bit timing, shifting and result loading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    datarx_d    = datarx_q;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_smp_d   = par_smp_q;
    par_chk_d   = par_chk_q;
    par_bit_d   = par_bit_q;
    par_err_d   = par_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Only a fresh 1->0 edge arms the receiver; a line held low after a
        // framing error never produces one.
        if (fall) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          if (!line) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (bit_tick) begin
          cnt_d     = '0;
          par_smp_d = line;
          par_chk_d = line ^ (^shift_q);
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_STOP: begin
        // Completing at mid stop bit leaves half a bit of slack so a start
        // edge at the nominal end of the stop bit is caught.
        if (bit_tick) begin
          cnt_d       = '0;
          datarx_d    = shift_q;
          frame_err_d = ~line;
          done_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_bit_d   = par_smp_q;
          par_err_d   = par_chk_q;
`endif
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output mapping; busy covers START through the completing edge.
  assign bus.datarx    = datarx_q;
  assign bus.donerx    = done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.state_dbg = state_q;
`ifdef UART_RX_PARITY_EN
  assign bus.par_bit_rx = par_bit_q;
  assign bus.par_err    = par_err_q;
`else
  assign bus.par_bit_rx = 1'b0;
  assign bus.par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_chk.sv
// tb_uart_rx_chk: directed bench for uart_rx_chk with a result scoreboard.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_chk;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 9600;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB       = 11;
  localparam int PAR_ON   = 1;
`else
  localparam int NB       = 10;
  localparam int PAR_ON   = 0;
`endif
  localparam int LAT      = 2 + HALF_CYC + (NB - 1) * BIT_CYC;
  localparam int W        = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_chk_if bus ();

  uart_rx_chk #(
    .clk_freq  (CLK_FREQ),
    .baud_rate (BAUD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           t0_q[$];
  int           done_t[$];
  int           done_cnt    = 0;
  logic         prev_done   = 1'b0;
  int           vectors     = 0;
  int           miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [7:0] d, input logic pb,
                                        input logic pe, input logic fe);
    return {d, pb, pe, fe};
  endfunction

  // Compare every strobe against the oldest expected frame and its timing.
  always @(negedge clk) begin
    if (rst && bus.donerx) begin
      done_cnt <= done_cnt + 1;
      done_t.push_back(cyc);
      chk("donerx_one_cycle", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_donerx", 32'd1, 32'd0);
      end else begin
        chk("frame_result",
            32'(pack(bus.datarx, bus.par_bit_rx, bus.par_err, bus.frame_err)),
            32'(exp_q.pop_front()));
        chk("donerx_latency", 32'(cyc - t0_q.pop_front()), 32'(LAT));
      end
    end
    prev_done <= bus.donerx;
  end

  // ---------------- driver tasks ----------------
  // Called on a negedge; holds the bit for one full bit time.
  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic stop);
    logic pb;
    pb = (^data) ^ bad_par;
    if (PAR_ON != 0) exp_q.push_back(pack(data, pb, bad_par, ~stop));
    else             exp_q.push_back(pack(data, 1'b0, 1'b0, ~stop));
    t0_q.push_back(cyc + 1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(pb);
`endif
    drive_bit(stop);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_datarx"},    32'(bus.datarx),     32'd0);
    chk({tag, "_donerx"},    32'(bus.donerx),     32'd0);
    chk({tag, "_busy"},      32'(bus.busy),       32'd0);
    chk({tag, "_par_bit"},   32'(bus.par_bit_rx), 32'd0);
    chk({tag, "_par_err"},   32'(bus.par_err),    32'd0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err),  32'd0);
  endtask

  // Hard stop if something wedges beyond any reasonable run length.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]   b;
    logic [W-1:0] snap;
    int           dc;
    int           t0;

    bus.rx = 1'b1;
    rst    = 1'b0;
    repeat (5) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_state", 32'(bus.state_dbg), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Good frame.
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_drain(4 * BIT_CYC);
    chk("a5_busy_after", 32'(bus.busy), 32'd0);

    // Wrong parity bit: flag held after the strobe.
    send_frame(8'h01, 1'b1, 1'b1);
    wait_drain(4 * BIT_CYC);
    chk("01_par_err_held", 32'(bus.par_err), 32'(PAR_ON));

    // Framing error with the line left low, then released.
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_drain(4 * BIT_CYC);
    dc = done_cnt;
    repeat (300) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    chk("3c_no_rearm", 32'(done_cnt), 32'(dc));
    chk("3c_frame_err_held", 32'(bus.frame_err), 32'd1);
    chk("3c_datarx_held", 32'(bus.datarx), 32'h3C);
    chk("3c_busy_idle", 32'(bus.busy), 32'd0);

    // 30-cycle glitch: start detected, rejected at mid start bit.
    snap = pack(bus.datarx, bus.par_bit_rx, bus.par_err, bus.frame_err);
    dc   = done_cnt;
    t0   = cyc + 1;
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_rise", 32'(bus.busy), 32'd1);
    repeat (20) @(negedge clk);
    bus.rx = 1'b1;
    while (cyc < t0 + 55) @(negedge clk);
    chk("glitch_busy_fall", 32'(bus.busy), 32'd0);
    chk("glitch_no_strobe", 32'(done_cnt), 32'(dc));
    chk("glitch_outputs",
        32'(pack(bus.datarx, bus.par_bit_rx, bus.par_err, bus.frame_err)), 32'(snap));
    repeat (2 * BIT_CYC) @(negedge clk);

    // Back-to-back frames, one stop bit each.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_drain(4 * BIT_CYC);
    if (done_t.size() >= 2)
      chk("b2b_interval", 32'(done_t[$] - done_t[$-1]), 32'(NB * BIT_CYC));
    else
      chk("b2b_strobe_count", 32'(done_t.size()), 32'd2);

    // Reset during data bit 4 of 0x5A.
    dc = done_cnt;
    b  = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    bus.rx = b[4];
    repeat (HALF_CYC) @(negedge clk);
    rst    = 1'b0;
    bus.rx = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    chk("midreset_no_strobe", 32'(done_cnt), 32'(dc));
    send_frame(8'h81, 1'b0, 1'b1);
    wait_drain(4 * BIT_CYC);
    chk("81_datarx", 32'(bus.datarx), 32'h81);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
